// File: rtl/bcd_binary_seq_if.sv
// Handshake bundle for bcd_binary_seq: start/operand in, status/result out.
// Parameters must match those of the attached converter.
interface bcd_binary_seq_if #(
  parameter int DIGITS = 2,
  parameter int OUT_W  = 7
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [OUT_W-1:0]      binary;
  logic                  overflow;
  logic                  invalid;

  modport master (
    output start, bcd_in,
    input  busy, done, binary, overflow, invalid
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, binary, overflow, invalid
  );
endinterface

// File: rtl/bcd_binary_seq.sv
// Serial packed-BCD to binary converter, one digit per clock, MS digit first.
// Define BCD_BINARY_INVALID_CHECK_EN to flag digits above 9 as invalid.
module bcd_binary_seq #(
  parameter int DIGITS = 2,
  parameter int OUT_W  = 7
) (
  input logic             clk,
  input logic             rst,
  bcd_binary_seq_if.slave bus
);

  // Sized for all-0xF digits so face-value accumulation never wraps.
  function automatic int acc_bits(input int d);
    longint unsigned m;
    m = 0;
    for (int i = 0; i < d; i++) m = m * 10 + 15;
    return $clog2(m + 1);
  endfunction

  localparam int ACC_W = acc_bits(DIGITS);
  localparam int W     = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam int CW    = $clog2(DIGITS) + 1;
  localparam logic [CW-1:0]    LAST = CW'(DIGITS - 1);
  localparam logic [ACC_W-1:0] TEN  = ACC_W'(10);
  localparam logic [W-1:0]     MAXV = W'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t              state_q;
  logic [4*DIGITS-1:0] opnd_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [CW-1:0]       cnt_q;
  logic [3:0]          dig;
  logic                busy_q;
  logic                done_q;
  logic [OUT_W-1:0]    bin_q;
  logic                ovf_q;
  logic                inv_q;
  logic [W-1:0]        val;
  logic [OUT_W-1:0]    res_bin;
  logic                res_ovf;
  logic                res_inv;

  assign dig   = opnd_q[4*DIGITS-1 -: 4];
  assign acc_d = acc_q * TEN + ACC_W'(dig);
  assign val   = W'(acc_d);

`ifdef BCD_BINARY_INVALID_CHECK_EN
  logic bad_q;
  logic bad_d;
  assign bad_d = bad_q | (dig > 4'd9);
`endif

  always_comb begin
    res_ovf = val > MAXV;
    res_bin = res_ovf ? '1 : OUT_W'(val);
    res_inv = 1'b0;
`ifdef BCD_BINARY_INVALID_CHECK_EN
    if (bad_d) begin
      res_bin = '0;
      res_ovf = 1'b0;
      res_inv = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
`ifdef BCD_BINARY_INVALID_CHECK_EN
      bad_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            opnd_q  <= bus.bcd_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
`ifdef BCD_BINARY_INVALID_CHECK_EN
            bad_q   <= 1'b0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CONV: begin
          acc_q  <= acc_d;
          opnd_q <= opnd_q << 4;
          cnt_q  <= cnt_q + 1'b1;
`ifdef BCD_BINARY_INVALID_CHECK_EN
          bad_q  <= bad_d;
`endif
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bin_q   <= res_bin;
            ovf_q   <= res_ovf;
            inv_q   <= res_inv;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.binary   = bin_q;
  assign bus.overflow = ovf_q;
  assign bus.invalid  = inv_q;

endmodule

// File: tb/tb_bcd_binary_seq.sv
// Randomized self-checking bench for bcd_binary_seq against a digit-sum model.
// Three instances cover the default, narrow-output and four-digit shapes.
module tb_bcd_binary_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_binary_seq_if #(.DIGITS(2), .OUT_W(7))  b0 ();
  bcd_binary_seq_if #(.DIGITS(2), .OUT_W(6))  b1 ();
  bcd_binary_seq_if #(.DIGITS(4), .OUT_W(14)) b2 ();

  bcd_binary_seq #(.DIGITS(2), .OUT_W(7))  u0 (.clk(clk), .rst(rst), .bus(b0));
  bcd_binary_seq #(.DIGITS(2), .OUT_W(6))  u1 (.clk(clk), .rst(rst), .bus(b1));
  bcd_binary_seq #(.DIGITS(4), .OUT_W(14)) u2 (.clk(clk), .rst(rst), .bus(b2));

`ifdef BCD_BINARY_INVALID_CHECK_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Value = sum of digit * 10^position, then saturate or flag.
  function automatic void model(input int digits, input int outw,
                                input longint unsigned bcd,
                                output longint unsigned bin,
                                output bit ovf, output bit inv);
    longint unsigned v;
    longint unsigned p;
    longint unsigned lim;
    v = 0;
    p = 1;
    inv = 1'b0;
    for (int i = 0; i < digits; i++) begin
      longint unsigned d;
      d = (bcd >> (4 * i)) & 64'd15;
      v += d * p;
      p *= 10;
      if (d > 9) inv = 1'b1;
    end
    inv = inv & INV_EN;
    lim = (64'd1 << outw) - 64'd1;
    ovf = 1'b0;
    if (inv) bin = 0;
    else if (v > lim) begin
      bin = lim;
      ovf = 1'b1;
    end else bin = v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run0(input logic [7:0] v, output int lat, output int bc,
                      output longint unsigned bin, output bit ovf,
                      output bit inv);
    b0.bcd_in = v;
    b0.start  = 1'b1;
    tick();
    lat = 0;
    bc  = 0;
    while (!b0.done && lat < 20) begin
      if (b0.busy) bc++;
      b0.start  = 1'($urandom_range(0, 1));
      b0.bcd_in = 8'($urandom);
      tick();
      lat++;
    end
    b0.start = 1'b0;
    bin = 64'(b0.binary);
    ovf = b0.overflow;
    inv = b0.invalid;
  endtask

  task automatic run1(input logic [7:0] v, output int lat,
                      output longint unsigned bin, output bit ovf,
                      output bit inv);
    b1.bcd_in = v;
    b1.start  = 1'b1;
    tick();
    b1.start = 1'b0;
    lat = 0;
    while (!b1.done && lat < 20) begin
      tick();
      lat++;
    end
    bin = 64'(b1.binary);
    ovf = b1.overflow;
    inv = b1.invalid;
  endtask

  task automatic run2(input logic [15:0] v, output int lat,
                      output longint unsigned bin, output bit ovf,
                      output bit inv);
    b2.bcd_in = v;
    b2.start  = 1'b1;
    tick();
    b2.start = 1'b0;
    lat = 0;
    while (!b2.done && lat < 20) begin
      b2.bcd_in = 16'($urandom);
      tick();
      lat++;
    end
    bin = 64'(b2.binary);
    ovf = b2.overflow;
    inv = b2.invalid;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    got = {b0.busy, b0.done, b0.binary, b0.overflow, b0.invalid};
    checks++;
    if (got !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", got);
    end
    checks++;
    if ({b2.busy, b2.done, b2.binary} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs_d4 got %0d exp 0", b2.binary);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    longint unsigned bin;
    bit ovf, inv;
    run0(8'h59, lat, bc, bin, ovf, inv);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL basic_latency got %0d exp 2", lat);
    end
    checks++;
    if (bc !== 2) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d exp 2", bc);
    end
    checks++;
    if (bin !== 64'd59 || ovf !== 1'b0 || inv !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got %0d/%0b/%0b exp 59/0/0",
               bin, ovf, inv);
    end
    tick();
    checks++;
    if (b0.done !== 1'b0 || b0.binary !== 7'd59) begin
      errors++;
      $display("FAIL basic_hold got done=%0b bin=%0d exp 0/59",
               b0.done, b0.binary);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    longint unsigned bin, eb;
    bit ovf, inv, eo, ei;
    logic [7:0] v;
    for (int n = 0; n < 24; n++) begin
      v = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 12))};
      model(2, 7, 64'(v), eb, eo, ei);
      run0(v, lat, bc, bin, ovf, inv);
      checks++;
      if (lat !== 2 || bin !== eb || ovf !== eo || inv !== ei) begin
        errors++;
        $display("FAIL random_%h got lat%0d %0d/%0b/%0b exp 2 %0d/%0b/%0b",
                 v, lat, bin, ovf, inv, eb, eo, ei);
      end
    end
  endtask

  task automatic test_invalid();
    int lat, bc;
    longint unsigned bin, eb;
    bit ovf, inv, eo, ei;
    model(2, 7, 64'h5A, eb, eo, ei);
    run0(8'h5A, lat, bc, bin, ovf, inv);
    checks++;
    if (bin !== eb || ovf !== eo || inv !== ei) begin
      errors++;
      $display("FAIL invalid_5A got %0d/%0b/%0b exp %0d/%0b/%0b",
               bin, ovf, inv, eb, eo, ei);
    end
    model(2, 7, 64'hFF, eb, eo, ei);
    run0(8'hFF, lat, bc, bin, ovf, inv);
    checks++;
    if (bin !== eb || ovf !== eo || inv !== ei) begin
      errors++;
      $display("FAIL invalid_FF got %0d/%0b/%0b exp %0d/%0b/%0b",
               bin, ovf, inv, eb, eo, ei);
    end
  endtask

  task automatic test_overflow6();
    int lat;
    longint unsigned bin, eb;
    bit ovf, inv, eo, ei;
    logic [7:0] v;
    run1(8'h99, lat, bin, ovf, inv);
    checks++;
    if (lat !== 2 || bin !== 64'd63 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf6_99 got lat%0d %0d/%0b exp 2 63/1", lat, bin, ovf);
    end
    for (int n = 0; n < 8; n++) begin
      v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      model(2, 6, 64'(v), eb, eo, ei);
      run1(v, lat, bin, ovf, inv);
      checks++;
      if (bin !== eb || ovf !== eo || inv !== ei) begin
        errors++;
        $display("FAIL ovf6_%h got %0d/%0b exp %0d/%0b", v, bin, ovf, eb, eo);
      end
    end
  endtask

  task automatic test_digits4();
    int lat;
    longint unsigned bin, eb;
    bit ovf, inv, eo, ei;
    logic [15:0] v;
    run2(16'h9999, lat, bin, ovf, inv);
    checks++;
    if (lat !== 4 || bin !== 64'd9999 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL d4_9999 got lat%0d %0d/%0b exp 4 9999/0", lat, bin, ovf);
    end
    for (int n = 0; n < 8; n++) begin
      v = 16'($urandom);
      model(4, 14, 64'(v), eb, eo, ei);
      run2(v, lat, bin, ovf, inv);
      checks++;
      if (lat !== 4 || bin !== eb || ovf !== eo || inv !== ei) begin
        errors++;
        $display("FAIL d4_%h got %0d/%0b/%0b exp %0d/%0b/%0b",
                 v, bin, ovf, inv, eb, eo, ei);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, gap;
    longint unsigned bin;
    bit ovf, inv;
    run0(8'h12, lat, bc, bin, ovf, inv);
    checks++;
    if (bin !== 64'd12) begin
      errors++;
      $display("FAIL b2b_first got %0d exp 12", bin);
    end
    b0.bcd_in = 8'h34;
    b0.start  = 1'b1;
    tick();
    b0.start = 1'b0;
    checks++;
    if (b0.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%0b exp 1", b0.busy);
    end
    gap = 1;
    while (!b0.done && gap < 20) begin
      tick();
      gap++;
    end
    checks++;
    if (gap !== 3 || b0.binary !== 7'd34) begin
      errors++;
      $display("FAIL b2b_second got gap%0d %0d exp 3 34", gap, b0.binary);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, seen;
    longint unsigned bin;
    bit ovf, inv;
    b0.bcd_in = 8'h77;
    b0.start  = 1'b1;
    tick();
    b0.start = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({b0.busy, b0.done, b0.binary, b0.overflow, b0.invalid} !== 10'd0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%0b bin=%0d exp 0/0",
               b0.busy, b0.binary);
    end
    tick();
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b0.done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d pulses exp 0", seen);
    end
    run0(8'h42, lat, bc, bin, ovf, inv);
    checks++;
    if (lat !== 2 || bin !== 64'd42) begin
      errors++;
      $display("FAIL after_reset got lat%0d %0d exp 2 42", lat, bin);
    end
  endtask

  initial begin
    b0.start = 1'b0;
    b0.bcd_in = '0;
    b1.start = 1'b0;
    b1.bcd_in = '0;
    b2.start = 1'b0;
    b2.bcd_in = '0;
    #2;
    rst = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_basic();
    test_random();
    test_invalid();
    test_overflow6();
    test_digits4();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_binary_seq.md
BCD_BINARY_SEQ -- requirements
Module: bcd_binary_seq

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of packed BCD digits converted (legal range 1..8).
REQ-002 SHALL have parameter OUT_W, default 7: width of the binary result in bits (legal range 1..32).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to convert bcd_in; sampled on clk.
REQ-006 SHALL have port bcd_in  input  4*DIGITS  packed BCD digits; most significant digit in the top nibble.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when binary, overflow and invalid are valid.
REQ-009 SHALL have port binary  output  OUT_W  converted result; holds its value until the next done.
REQ-010 SHALL have port overflow  output  1  result exceeded 2^OUT_W-1; updated with done.
REQ-011 SHALL have port invalid  output  1  a digit above 9 was seen; updated with done.

Function
REQ-012 SHALL implement an FSM with states IDLE, CONV and DONE; DONE lasts exactly one cycle.
REQ-013 IDLE or DONE with start=1: SHALL latch bcd_in, clear the accumulator and the sticky flags, and go to CONV.
REQ-014 DONE with start=0 SHALL go to IDLE; IDLE with start=0 SHALL stay in IDLE.
REQ-015 Each CONV cycle SHALL process one digit, MS digit first: acc <= acc*10 + digit.
REQ-016 The accumulator SHALL be wide enough to hold 10^DIGITS-1 without wrap, independent of OUT_W.
REQ-017 After the DIGITS-th CONV edge the FSM SHALL enter DONE and register binary, overflow, invalid and done=1 on that same edge.
REQ-018 Latency from the edge that samples start to the edge that raises done SHALL be exactly DIGITS clocks.
REQ-019 busy SHALL be 1 exactly while the state is CONV.
REQ-020 start and bcd_in changes during CONV SHALL be ignored; the latched operand is used.
REQ-021 If the final value is greater than 2^OUT_W-1: binary SHALL saturate to all ones, with overflow=1.
REQ-022 If the final value fits: binary SHALL equal the value zero-extended or truncated to OUT_W bits, with overflow=0.
REQ-023 start in a DONE cycle SHALL be accepted, so back-to-back conversions occur every DIGITS+1 cycles.
REQ-024 binary, overflow and invalid SHALL change only on the edge that raises done, or on reset.

Reset
REQ-025 rst=0 SHALL immediately force state=IDLE and busy=0, done=0, binary=0, overflow=0, invalid=0, and clear the accumulator.
REQ-026 Reset during CONV SHALL abort the conversion without any done pulse.
REQ-027 After rst is released, the first start SHALL behave as from IDLE.

Configuration
REQ-028 Macro BCD_BINARY_INVALID_CHECK_EN defined: a digit greater than 9 SHALL set a sticky flag during CONV.
REQ-029 With the macro defined and the flag set: done SHALL report invalid=1, binary=0 and overflow=0.
REQ-030 Macro not defined: invalid SHALL be tied to 0, and digits 10..15 SHALL be accumulated at their face value.

Verification
REQ-031 DIGITS=2, OUT_W=7, bcd_in=8'h59, start -> done 2 clocks later; binary=59, overflow=0, busy high for 2 cycles.
REQ-032 DIGITS=2, OUT_W=6, bcd_in=8'h99 -> binary=63, overflow=1.
REQ-033 bcd_in=8'h5A -> with BCD_BINARY_INVALID_CHECK_EN: invalid=1, binary=0; without it: binary=60, invalid=0.
REQ-034 start with 8'h12, held high in the DONE cycle with bcd_in=8'h34 -> done pulses 3 cycles apart reporting 12, then 34.
REQ-035 rst=0 one cycle into CONV -> all outputs 0 immediately, and no done follows.
REQ-036 DIGITS=4, OUT_W=14, bcd_in=16'h9999 -> done 4 clocks later with binary=9999 and overflow=0.
